mem_access_sequencer: RTL and testbench
=======================================

# mem_access_sequencer

Initiator for the byte-wide `memory_array` port. The block accepts one 32-bit load or store request at a time from the core's memory stage, using RISC-V funct3 sizes. It sequences the request into little-endian single-byte accesses, then returns a sign- or zero-extended load result, or a store completion, as a one-cycle response pulse. It sits between the datapath and `memory_array`, and is the only driver of the memory's write_enable, address and data_in.

## Interface
Parameters:
- MEM_DEPTH, 1024: number of byte locations in the attached memory. Any access touching an address ≥ MEM_DEPTH is an error.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high. All state returns to IDLE immediately.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE. A request is accepted on a rising edge with req_valid & req_ready.
- req_is_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  32  byte address of the lowest byte. No alignment requirement.
- req_wdata  input  32  store data; the low N bytes are used.
- resp_valid  output  1  one-cycle completion pulse. No backpressure.
- resp_rdata  output  32  extended load data. It is 0 for stores and errors, and holds its value until the next resp_valid.
- resp_error  output  1  qualified by resp_valid: illegal funct3 or out-of-range address.
- mem_write_enable  output  1  to memory write_enable.
- mem_address  output  32  to memory address.
- mem_data_in  output  8  to memory data_in.
- mem_data_out  input  8  from memory data_out. It is registered, so valid the cycle after a read address is presented.

## Operation
- States: IDLE, ACCESS, CAPTURE, RESP.

IDLE:
- Drives req_ready=1 and mem_write_enable=0.
- On accept, latch addr, wdata, funct3, is_store, and set byte counter k=0.
- Byte count N: funct3[1:0] 00→1, 01→2, 10→4.
- Illegal requests are 011, 11x, 1xx with a store, or a load with 110/111. An illegal request goes to RESP with error=1 and makes no memory access.
- Range check: compute {1'b0,addr}+N-1 in 33 bits. If the result ≥ MEM_DEPTH, go to RESP with error=1 and make no access. Wrap past 2^32 is therefore an error.
- Otherwise go to ACCESS.

ACCESS (N cycles):
- mem_address = addr + k.
- Store: mem_write_enable=1, mem_data_in = wdata[8k+:8].
- Load: mem_write_enable=0, mem_data_in=0.
- For a load with k ≥ 1, capture mem_data_out into byte k-1 of the assembly register.
- At k==N-1: a load goes to CAPTURE, a store goes to RESP.

CAPTURE (load only):
- mem_write_enable=0, mem_address held at addr+N-1.
- Capture byte N-1.
- Compute the extended result: B/H sign-extend from bit 8N-1, BU/HU zero-extend, W passes through.
- Go to RESP.

RESP:
- resp_valid=1 for exactly one cycle, with resp_rdata/resp_error registered.
- mem_write_enable=0.
- Go to IDLE; the next request can be accepted on the following edge.

Other rules:
- req_valid while not ready is ignored; the requester holds it.
- Request inputs are don't-care after acceptance.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_write_enable=0, mem_address=0, mem_data_in=0.
- Memory-side outputs are registered or decoded from registered state, with no combinational path from req_* to mem_*.
- Store latency: accept edge, then N ACCESS cycles, then RESP. resp_valid is high N+1 cycles after accept (SW: 5).
- Load latency: accept edge, then N ACCESS cycles, then CAPTURE, then RESP. resp_valid is high N+2 cycles after accept (LW: 6, LB: 3).
- Error latency: resp_valid is high 1 cycle after accept, with zero memory cycles.
- Back-to-back throughput: a new accept is possible the cycle after RESP.
- Reset mid-ACCESS: mem_write_enable drops asynchronously. A partially written store is not rolled back, and no resp_valid is produced for the aborted request.

## Structure
- Package mem_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP};
  - function size_bytes(funct3) returning 3 bits;
  - function funct3_legal(funct3, is_store).
- One sub-module, load_extender: combinational, taking funct3 and the 32-bit assembled value and producing the extended 32-bit result. It is instantiated once in CAPTURE.
- The top level holds the FSM, latched request, counter, assembly register and range check.

## Test plan
- Word store then load: SW addr 0x10, data 0xDEADBEEF. Bytes 0x10..0x13 receive EF,BE,AD,DE, with resp_valid at +5. LW 0x10 gives resp_rdata=0xDEADBEEF at +6.
- Sign/zero extension: memory[0x20]=0x80, memory[0x21]=0xFF. LB 0x20 → 0xFFFFFF80, LBU 0x20 → 0x00000080, LH 0x20 → 0xFFFFFF80, LHU 0x20 → 0x0000FF80.
- Unaligned: SH addr 0x3FE, data 0x1234 writes 0x3FE=34 and 0x3FF=12. LW addr 0x3FD gives resp_error=1 at +1, rdata 0, and mem_write_enable never rises.
- Illegal funct3: store with funct3=100 or load with 011. resp_error=1 at +1, with no mem_write_enable and no address change.
- Backpressure and back-to-back: req_valid held high with two LWs queued. req_ready is low for 6 cycles; the second request is accepted the cycle after the first resp_valid, and both results are correct.
- Reset mid-store: assert reset during ACCESS k=1 of SW 0x40. Only byte 0x40 is written, mem_write_enable goes low asynchronously, there is no resp_valid, and all outputs take their reset values.

Source files
------------

// File: rtl/mem_access_sequencer_pkg.sv
// Shared definitions for the byte-serial load/store sequencer: funct3 codes,
// FSM state encoding and request decode helpers.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    // Unsigned widths only make sense for loads.
    function automatic logic funct3_legal(input logic [2:0] funct3, input logic is_store);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !is_store;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_sequencer_load_extender.sv
// Widens an assembled little-endian load value to 32 bits according to funct3.
module load_extender
    import mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (funct3_i)
            F3_B:    data_o = {{24{data_i[7]}}, data_i[7:0]};
            F3_H:    data_o = {{16{data_i[15]}}, data_i[15:0]};
            F3_BU:   data_o = {24'h000000, data_i[7:0]};
            F3_HU:   data_o = {16'h0000, data_i[15:0]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Splits one 32-bit load/store request into little-endian byte accesses on a
// byte-wide memory with a registered read port, and returns a one-cycle response.
module mem_access_sequencer
    import mem_pkg::*;
#(
    parameter int MEM_DEPTH = 1024
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_is_store_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_error_o,
    output logic        mem_write_enable_o,
    output logic [31:0] mem_address_o,
    output logic [7:0]  mem_data_in_o,
    input  logic [7:0]  mem_data_out_i
);

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;
    logic        is_store_q;
    logic [1:0]  k_q;
    logic [31:0] asm_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_error_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [7:0]  mem_din_q;

    logic [2:0]  req_size_d;
    logic [32:0] req_last_d;
    logic        req_ok_d;
    logic [1:0]  last_k_d;
    logic [1:0]  k_next_d;
    logic [1:0]  capture_lane_d;
    logic [31:0] asm_d;
    logic [31:0] ext_data_d;
    logic [7:0]  wbyte [4];

    // 33-bit sum so an access wrapping past 2^32 lands out of range.
    assign req_size_d = size_bytes(req_funct3_i);
    assign req_last_d = {1'b0, req_addr_i} + {30'b0, req_size_d} - 33'd1;
    assign req_ok_d   = funct3_legal(req_funct3_i, req_is_store_i)
                        && (req_last_d < 33'(MEM_DEPTH));

    assign last_k_d = 2'(size_bytes(f3_q) - 3'd1);
    assign k_next_d = k_q + 2'd1;

    // Read data trails the address by one cycle, so ACCESS k fills lane k-1.
    assign capture_lane_d = (state_q == CAPTURE) ? last_k_d : (k_q - 2'd1);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wbyte[gi]           = wdata_q[8*gi +: 8];
        assign asm_d[8*gi +: 8]    = (capture_lane_d == 2'(gi)) ? mem_data_out_i
                                                                : asm_q[8*gi +: 8];
    end

    load_extender u_load_extender (
        .funct3_i (f3_q),
        .data_i   (asm_d),
        .data_o   (ext_data_d)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            f3_q         <= '0;
            is_store_q   <= 1'b0;
            k_q          <= '0;
            asm_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q     <= req_addr_i;
                        wdata_q    <= req_wdata_i;
                        f3_q       <= req_funct3_i;
                        is_store_q <= req_is_store_i;
                        k_q        <= '0;
                        asm_q      <= '0;
                        if (!req_ok_d) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q    <= ACCESS;
                            mem_addr_q <= req_addr_i;
                            mem_we_q   <= req_is_store_i;
                            mem_din_q  <= req_is_store_i ? req_wdata_i[7:0] : 8'h00;
                        end
                    end
                end
                ACCESS: begin
                    if (!is_store_q && (k_q != 2'd0)) begin
                        asm_q <= asm_d;
                    end
                    if (k_q == last_k_d) begin
                        if (is_store_q) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b0;
                            resp_rdata_q <= '0;
                            mem_we_q     <= 1'b0;
                            mem_din_q    <= '0;
                        end else begin
                            state_q <= CAPTURE;
                        end
                    end else begin
                        k_q        <= k_next_d;
                        mem_addr_q <= addr_q + 32'(k_next_d);
                        mem_din_q  <= is_store_q ? wbyte[k_next_d] : 8'h00;
                    end
                end
                CAPTURE: begin
                    asm_q        <= asm_d;
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_error_q <= 1'b0;
                    resp_rdata_q <= ext_data_d;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o        = (state_q == IDLE);
    assign resp_valid_o       = resp_valid_q;
    assign resp_rdata_o       = resp_rdata_q;
    assign resp_error_o       = resp_error_q;
    assign mem_write_enable_o = mem_we_q;
    assign mem_address_o      = mem_addr_q;
    assign mem_data_in_o      = mem_din_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench: table of requests against a byte memory model, with a
// response scoreboard, a back-to-back sequence and a reset-mid-store sequence.
module tb_mem_access_sequencer;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic        mem_clr;

    always #5 clk = ~clk;

    mem_access_sequencer #(.MEM_DEPTH(1024)) dut (
        .clk_i              (clk),
        .reset_i            (rst),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_is_store_i     (req_is_store),
        .req_funct3_i       (req_funct3),
        .req_addr_i         (req_addr),
        .req_wdata_i        (req_wdata),
        .resp_valid_o       (resp_valid),
        .resp_rdata_o       (resp_rdata),
        .resp_error_o       (resp_error),
        .mem_write_enable_o (mem_we),
        .mem_address_o      (mem_addr),
        .mem_data_in_o      (mem_din),
        .mem_data_out_i     (mem_dout)
    );

    // Byte memory with registered read port
    logic [7:0] mem [1024];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else if (mem_we && mem_addr < 32'd1024) begin
            mem[mem_addr[9:0]] <= mem_din;
        end
        mem_dout <= (mem_addr < 32'd1024) ? mem[mem_addr[9:0]] : 8'h00;
    end

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_we;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[21];
    int   passed = 0;
    int   total = 0;
    int   cyc = 0;
    int   we_cnt = 0;
    int   resp_cnt = 0;
    int   last_acc = 0;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_we) we_cnt <= we_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Scoreboard: every response is matched against the oldest accepted request
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            resp_cnt++;
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_resp: got resp_valid=1 rdata=0x%08h, expected no response", resp_rdata);
            end else begin
                mon_e = sb.pop_front();
                $display("resp: rdata=0x%08h err=%0b lat=%0d (exp 0x%08h err=%0b lat=%0d)",
                         resp_rdata, resp_error, cyc - mon_e.acc + 1, mon_e.rdata, mon_e.err, mon_e.lat);
                check("resp_rdata", resp_rdata, mon_e.rdata);
                check("resp_error", {31'b0, resp_error}, {31'b0, mon_e.err});
                check("latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input vec_t v, output int waits);
        req_is_store = v.st;
        req_funct3   = v.f3;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_valid    = 1'b1;
        waits = 0;
        while (!req_ready && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        if (!req_ready) begin
            total++;
            $display("FAIL accept_timeout: got req_ready=0 after %0d cycles, expected 1", waits);
            req_valid = 1'b0;
            return;
        end
        last_acc = cyc + 1;
        sb.push_back('{v.exp_rdata, v.exp_err, v.exp_lat, cyc + 1});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            $display("FAIL resp_timeout: got %0d pending responses, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w, w2, a1, a2, we0, rc0;
        logic [31:0] addr0;
        vec_t p1, p2, rv;

        rst = 1'b1; mem_clr = 1'b1; req_valid = 1'b0; req_is_store = 1'b0;
        req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        mem_clr = 1'b0;
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_error", {31'b0, resp_error}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_din", {24'b0, mem_din}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        //          st    f3     addr           wdata          rdata          err  lat we
        vecs[0]  = '{1'b1, F3_W,  32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 5, 4};
        vecs[1]  = '{1'b0, F3_W,  32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 6, 0};
        vecs[2]  = '{1'b1, F3_B,  32'h0000_0020, 32'h0000_0080, 32'h0000_0000, 1'b0, 2, 1};
        vecs[3]  = '{1'b1, F3_B,  32'h0000_0021, 32'h5555_55FF, 32'h0000_0000, 1'b0, 2, 1};
        vecs[4]  = '{1'b0, F3_B,  32'h0000_0020, 32'h0,         32'hFFFF_FF80, 1'b0, 3, 0};
        vecs[5]  = '{1'b0, F3_BU, 32'h0000_0020, 32'h0,         32'h0000_0080, 1'b0, 3, 0};
        vecs[6]  = '{1'b0, F3_H,  32'h0000_0020, 32'h0,         32'hFFFF_FF80, 1'b0, 4, 0};
        vecs[7]  = '{1'b0, F3_HU, 32'h0000_0020, 32'h0,         32'h0000_FF80, 1'b0, 4, 0};
        vecs[8]  = '{1'b1, F3_H,  32'h0000_03FE, 32'hAAAA_1234, 32'h0000_0000, 1'b0, 3, 2};
        vecs[9]  = '{1'b0, F3_HU, 32'h0000_03FE, 32'h0,         32'h0000_1234, 1'b0, 4, 0};
        vecs[10] = '{1'b0, F3_W,  32'h0000_03FD, 32'h0,         32'h0000_0000, 1'b1, 1, 0};
        vecs[11] = '{1'b1, F3_BU, 32'h0000_0050, 32'h1111_1111, 32'h0000_0000, 1'b1, 1, 0};
        vecs[12] = '{1'b0, 3'b011,32'h0000_0050, 32'h0,         32'h0000_0000, 1'b1, 1, 0};
        vecs[13] = '{1'b0, 3'b110,32'h0000_0050, 32'h0,         32'h0000_0000, 1'b1, 1, 0};
        vecs[14] = '{1'b1, F3_HU, 32'h0000_0050, 32'h2222_2222, 32'h0000_0000, 1'b1, 1, 0};
        vecs[15] = '{1'b0, F3_W,  32'hFFFF_FFFF, 32'h0,         32'h0000_0000, 1'b1, 1, 0};
        vecs[16] = '{1'b0, F3_B,  32'h0000_03FF, 32'h0,         32'h0000_0012, 1'b0, 3, 0};
        vecs[17] = '{1'b0, F3_W,  32'h0000_03FC, 32'h0,         32'h1234_0000, 1'b0, 6, 0};
        vecs[18] = '{1'b1, F3_W,  32'h0000_0011, 32'hA1B2_C3D4, 32'h0000_0000, 1'b0, 5, 4};
        vecs[19] = '{1'b0, F3_W,  32'h0000_0010, 32'h0,         32'hB2C3_D4EF, 1'b0, 6, 0};
        vecs[20] = '{1'b0, F3_H,  32'h0000_03FF, 32'h0,         32'h0000_0000, 1'b1, 1, 0};

        for (int i = 0; i < 21; i++) begin
            we0   = we_cnt;
            addr0 = mem_addr;
            $display("vec %0d: st=%0b f3=%03b addr=0x%08h wdata=0x%08h", i,
                     vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
            issue(vecs[i], w);
            wait_done();
            @(negedge clk);
            check("we_cycles", 32'(we_cnt - we0), 32'(vecs[i].exp_we));
            if (vecs[i].exp_err) check("err_addr_unchanged", mem_addr, addr0);
        end
        check("mem_3fe", {24'b0, mem[10'h3FE]}, 32'h34);
        check("mem_3ff", {24'b0, mem[10'h3FF]}, 32'h12);

        // Two loads queued with req_valid held high
        p1 = '{1'b0, F3_W, 32'h0000_0010, 32'h0, 32'hB2C3_D4EF, 1'b0, 6, 0};
        p2 = '{1'b0, F3_W, 32'h0000_03FC, 32'h0, 32'h1234_0000, 1'b0, 6, 0};
        issue(p1, w);
        a1 = last_acc;
        issue(p2, w2);
        a2 = last_acc;
        $display("b2b: accepts at cycles %0d and %0d, ready low %0d cycles", a1, a2, w2);
        check("b2b_accept_gap", 32'(a2 - a1), 32'd7);
        check("b2b_ready_low", 32'(w2), 32'd6);
        wait_done();
        @(negedge clk);

        // Reset during the second byte of a word store
        rc0 = resp_cnt;
        req_is_store = 1'b1; req_funct3 = F3_W; req_addr = 32'h40; req_wdata = 32'h1122_3344;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 check("pre_rst_mem_we", {31'b0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        $display("reset mid-store: we=%0b addr=0x%08h", mem_we, mem_addr);
        check("arst_mem_we", {31'b0, mem_we}, 32'd0);
        check("arst_mem_addr", mem_addr, 32'd0);
        check("arst_mem_din", {24'b0, mem_din}, 32'd0);
        check("arst_resp_rdata", resp_rdata, 32'd0);
        check("arst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("arst_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_no_resp", 32'(resp_cnt - rc0), 32'd0);
        check("abort_mem_40", {24'b0, mem[10'h040]}, 32'h44);
        check("abort_mem_41", {24'b0, mem[10'h041]}, 32'h00);

        rv = '{1'b0, F3_B, 32'h0000_0040, 32'h0, 32'h0000_0044, 1'b0, 3, 0};
        issue(rv, w);
        wait_done();
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
